// File: rtl/step_dir_pkg.sv
// Shared types and shortest-path helper for the step/direction command generator.
package step_dir_pkg;

    localparam int unsigned PATH_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              up;
        logic [PATH_W-1:0] remaining;
    } path_t;

    // Half of a ring of 2^width positions: the longest move ever taken.
    function automatic logic [PATH_W-1:0] half_ring(input int unsigned width);
        return 32'd1 << (width - 32'd1);
    endfunction

    // Direction and step count of the shortest modular path; a tie goes up.
    function automatic path_t shortest_path(input logic [PATH_W-1:0] pos,
                                            input logic [PATH_W-1:0] tgt,
                                            input int unsigned       width);
        path_t             res;
        logic [PATH_W-1:0] mask;
        logic [PATH_W-1:0] diff;
        mask          = (32'd1 << width) - 32'd1;
        diff          = (tgt - pos) & mask;
        res.up        = (diff <= half_ring(width));
        res.remaining = res.up ? diff : ((mask - diff) + 32'd1);
        return res;
    endfunction

endpackage

// File: rtl/step_gap_timer.sv
// Down-counter spacing successive step pulses; flags when the gap has elapsed.
module step_gap_timer
    import step_dir_pkg::*;
#(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int            CW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] r_cnt;

    // Load on entry to the gap, then count down while the gap runs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_run && (r_cnt != {CW{1'b0}})) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // The value seen in the last gap cycle is 1, so the FSM leaves on that edge.
    assign o_expired = (r_cnt <= CNT_ONE);

endmodule

// File: rtl/step_dir_gen.sv
// Step/direction driver mirroring a downstream up/down counter along the shortest path.
// Optional abort input enabled by defining STEP_DIR_ABORT_EN.
module step_dir_gen
    import step_dir_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
`ifdef STEP_DIR_ABORT_EN
    input  logic             abort,
`endif
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_value,
    output logic             step,
    output logic             up_down,
    output logic [WIDTH-1:0] pos,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_pos;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_tgt;
    logic             r_up;
    logic             r_step;
    logic             r_done;
    logic             r_busy;
    logic             r_ready;

    state_t           w_nxt_state;
    logic [WIDTH-1:0] w_nxt_pos;
    logic [WIDTH-1:0] w_nxt_rem;
    logic [WIDTH-1:0] w_nxt_tgt;
    logic             w_nxt_up;
    logic             w_nxt_step;
    logic             w_nxt_done;
    logic             w_gap_load;
    logic             w_gap_expired;
    logic             w_abort;
    logic             w_last;
    logic [WIDTH-1:0] w_pos_step;
    path_t            w_path;

`ifdef STEP_DIR_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_path     = shortest_path(32'(r_pos), 32'(tgt_value), WIDTH);
    assign w_pos_step = r_up ? (r_pos + ONE_W) : (r_pos - ONE_W);
    assign w_last     = (r_rem <= ONE_W);

    step_gap_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_gap_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_gap_load),
        .i_run     (r_state == GAP),
        .o_expired (w_gap_expired)
    );

    // Next-state and next-output decode for the IDLE/MOVE/GAP sequencer.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pos   = r_pos;
        w_nxt_rem   = r_rem;
        w_nxt_tgt   = r_tgt;
        w_nxt_up    = r_up;
        w_nxt_step  = 1'b0;
        w_nxt_done  = 1'b0;
        w_gap_load  = 1'b0;
        case (r_state)
            IDLE: begin
                if (tgt_valid && r_ready) begin
                    w_nxt_tgt = tgt_value;
                    if (w_path.remaining == 32'd0) begin
                        w_nxt_done = 1'b1;
                    end else begin
                        w_nxt_up    = w_path.up;
                        w_nxt_rem   = WIDTH'(w_path.remaining);
                        w_nxt_state = MOVE;
                        w_nxt_step  = 1'b1;
                    end
                end else begin
                    w_nxt_tgt = r_tgt;
                end
            end
            MOVE: begin
                // The step pulsed this cycle is committed to the mirror even when aborted.
                w_nxt_pos = w_pos_step;
                if (w_abort) begin
                    w_nxt_state = IDLE;
                    w_nxt_rem   = {WIDTH{1'b0}};
                end else if (w_last) begin
                    w_nxt_state = IDLE;
                    w_nxt_rem   = {WIDTH{1'b0}};
                    w_nxt_done  = (w_pos_step == r_tgt);
                end else if (STEP_DIV == 1) begin
                    w_nxt_rem  = r_rem - ONE_W;
                    w_nxt_step = 1'b1;
                end else begin
                    w_nxt_rem   = r_rem - ONE_W;
                    w_nxt_state = GAP;
                    w_gap_load  = 1'b1;
                end
            end
            GAP: begin
                if (w_abort) begin
                    w_nxt_state = IDLE;
                    w_nxt_rem   = {WIDTH{1'b0}};
                end else if (w_gap_expired) begin
                    w_nxt_state = MOVE;
                    w_nxt_step  = 1'b1;
                end else begin
                    w_nxt_state = GAP;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_rem   = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, position mirror and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pos   <= {WIDTH{1'b0}};
            r_rem   <= {WIDTH{1'b0}};
            r_tgt   <= {WIDTH{1'b0}};
            r_up    <= 1'b1;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_pos   <= w_nxt_pos;
            r_rem   <= w_nxt_rem;
            r_tgt   <= w_nxt_tgt;
            r_up    <= w_nxt_up;
            r_step  <= w_nxt_step;
            r_done  <= w_nxt_done;
            r_busy  <= (w_nxt_state != IDLE);
            r_ready <= (w_nxt_state == IDLE);
        end
    end

    assign tgt_ready = r_ready;
    assign step      = r_step;
    assign up_down   = r_up;
    assign pos       = r_pos;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/step_dir_gen.md
Name: step_dir_gen

Overview:
- Command-side driver for the team's up/down counter.
- Accepts a target position over a valid/ready handshake and emits single-cycle step pulses with a held up_down direction. Each step moves the downstream counter one position.
- Keeps an internal mirror of the counter position. Always moves along the shortest modular path, and pulses done when the target is reached.

Parameters:
- WIDTH, 4, position width in bits; matches the count width of the downstream counter.
- STEP_DIV, 1, clock cycles per step, minimum 1. A value of 1 gives back-to-back steps.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset; synchronous, active-low.
- tgt_valid  input  1  target offer.
- tgt_ready  output  1  high only in IDLE.
- tgt_value  input  WIDTH  target position.
- step  output  1  one-cycle pulse; the downstream counter moves one position per pulse.
- up_down  output  1  direction: 1 = up, 0 = down. Held stable for the whole move.
- pos  output  WIDTH  mirror of the downstream counter position.
- busy  output  1  high in MOVE and GAP.
- done  output  1  one-cycle pulse when pos equals the latched target.

Behaviour:
- Reset: at any posedge with reset=0, these values take effect from the next cycle:
  - state=IDLE, pos=0, step=0, up_down=1, busy=0, done=0, tgt_ready=1.
  - Target and remaining-step registers clear.
  - Reset mid-move aborts immediately; no further step pulses.
- States: IDLE, MOVE, GAP. All outputs are registered.
- IDLE:
  - tgt_ready=1.
  - Handshake when tgt_valid && tgt_ready at edge N. Latch tgt_value and compute diff = (tgt_value - pos) mod 2^WIDTH.
  - If diff==0: done=1 in cycle N+1, no step, remain in IDLE.
  - Else: up_down = (diff <= 2^(WIDTH-1)); a tie goes up. Set remaining = up ? diff : 2^WIDTH - diff. Enter MOVE; step=1 in cycle N+1.
- MOVE:
  - step=1 for exactly one cycle.
  - At the end of that cycle, pos moves by ±1 (wrapping modulo 2^WIDTH) and remaining decrements.
  - If remaining becomes 0: go to IDLE and assert done=1 in the next cycle.
  - Else if STEP_DIV==1: stay in MOVE, so step stays high continuously.
  - Else: go to GAP.
- GAP: step=0 for STEP_DIV-1 cycles, then return to MOVE.
- Handshake while busy: tgt_ready=0 and tgt_valid is ignored. The source must hold its offer until it is accepted.
- Path limits: a move is at most 2^(WIDTH-1) steps, and never crosses more than half the ring.
- Latency: for a k-step move, done is high in cycle N + 1 + (k-1)*STEP_DIV + 1.
- done and tgt_ready both rise in the first IDLE cycle after the move. A new handshake may occur on that edge.
- up_down may change only on a handshake edge.
- Invariant: pos always equals the downstream count when the counter advances once per step.

Optional Feature:
- STEP_DIR_ABORT_EN: adds input abort (1 bit).
- With the macro: abort=1 sampled in MOVE or GAP forces IDLE at that edge. step=0 from the next cycle, pos keeps the steps already issued, done is not pulsed, and tgt_ready=1 in the next cycle. abort in IDLE has no effect.
- Without the macro: the port and its logic are absent, and moves always run to completion.

Decomposition:
- Package step_dir_pkg holds:
  - state enum typedef {IDLE, MOVE, GAP}.
  - Function shortest_path(pos, tgt), returning direction and remaining count (tie goes up).
  - Localparam for the half-ring constant.
- One sub-module, step_gap_timer: a down-counter loaded with STEP_DIV-1 that flags expiry. It is unused when STEP_DIV==1.
- The top level holds the FSM, the pos mirror and the handshake logic.

Test Plan (WIDTH=4, STEP_DIV=1 unless stated):
- Reset held 3 cycles then released; offer target 3 → tgt_ready drops; up_down=1; step high 3 cycles; pos 1,2,3; done one cycle; tgt_ready=1.
- pos=3, target 14 → up_down=0; 5 steps; pos 2,1,0,15,14 (wrap); done.
- pos=0, target 8 (tie) → up_down=1; 8 steps; pos=8. Then target 8 again → done next cycle, step never high.
- STEP_DIV=3, pos=0, target 2 → step high at N+1 and N+4, low in between; done at N+5.
- Reset driven low after 2 of 5 steps → pos=0 and step=0 next cycle; no done; tgt_ready=1. tgt_valid held while busy is not accepted before IDLE.
- With STEP_DIR_ABORT_EN: abort after 2 of 6 up steps from pos=0 → pos=2; no done; new target accepted on the next cycle.
